vga_compositor: RTL and testbench

Display-side endpoint for the game's sprite renderers. Generates 640x480@60 Hz VGA raster timing (hcount/vcount, hsync/vsync), broadcasts the counters to every sprite/enemy block, and collects their registered per-pixel {color, data} outputs. A fixed-priority mux merges those outputs into one RGB332 stream, applies blanking, and aligns sync to the pixel pipeline. Sits between the sprite layer bank and the board VGA pins; its input is the 25 MHz pixel clock.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_timing.sv | 77 +++++++
 rtl/vga_compositor.sv | 128 ++++++++++++
 tb/tb_vga_compositor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, RGB332 field widths and layer slice width
// for the compositor and its timing generator.
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL_DEF   = 800;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL_DEF   = 525;

  localparam int RED_W   = 3;
  localparam int GREEN_W = 3;
  localparam int BLUE_W  = 2;
  localparam int RGB_W   = RED_W + GREEN_W + BLUE_W;

  localparam int LAYER_W = 8;

  localparam logic [RGB_W-1:0] BG_COLOR_DEF = 8'b000_000_01;

endpackage

// File: rtl/vga_timing.sv
// Raster counters, frame_start pulse and the raw (unaligned) sync/visible
// decode taken directly from the current counter values.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic       clock,
  input  logic       reset,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       frame_start,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       visible_raw
);

  localparam logic [9:0] H_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       frame_start_q, frame_start_d;
  logic       h_last_s, v_last_s;

  always_comb begin
    h_last_s      = (hcount_q == H_LAST);
    v_last_s      = (vcount_q == V_LAST);
    hcount_d      = hcount_q + 10'd1;
    vcount_d      = vcount_q;
    if (h_last_s) begin
      hcount_d = 10'd0;
      if (v_last_s) begin
        vcount_d = 10'd0;
      end else begin
        vcount_d = vcount_q + 10'd1;
      end
    end else begin
      hcount_d = hcount_q + 10'd1;
    end
    // Registered alongside the counters, so it is high exactly while they read (0,0).
    frame_start_d = h_last_s && v_last_s;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_start = frame_start_q;
  assign hsync_raw   = !((hcount_q >= H_SYNC_LO) && (hcount_q < H_SYNC_HI));
  assign vsync_raw   = !((vcount_q >= V_SYNC_LO) && (vcount_q < V_SYNC_HI));
  assign visible_raw = (hcount_q < H_VIS) && (vcount_q < V_VIS);

endmodule

// File: rtl/vga_compositor.sv
// VGA raster endpoint: merges registered sprite layers by fixed priority into RGB332,
// blanks, and aligns sync. Define VGA_COMPOSITOR_COLLISION_EN for per-frame collision flags.
module vga_compositor
  import vga_pkg::*;
#(
  parameter int               NUM_LAYERS = 8,
  parameter int               H_VISIBLE  = H_VISIBLE_DEF,
  parameter int               H_FRONT    = H_FRONT_DEF,
  parameter int               H_SYNC     = H_SYNC_DEF,
  parameter int               H_BACK     = H_BACK_DEF,
  parameter int               V_VISIBLE  = V_VISIBLE_DEF,
  parameter int               V_FRONT    = V_FRONT_DEF,
  parameter int               V_SYNC     = V_SYNC_DEF,
  parameter int               V_BACK     = V_BACK_DEF,
  parameter logic [RGB_W-1:0] BG_COLOR   = BG_COLOR_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_LAYERS-1:0]         layer_data,
  input  logic [LAYER_W*NUM_LAYERS-1:0] layer_rgb,
  output logic [9:0]                    hcount,
  output logic [9:0]                    vcount,
  output logic                          hsync,
  output logic                          vsync,
  output logic [RED_W-1:0]              red,
  output logic [GREEN_W-1:0]            green,
  output logic [BLUE_W-1:0]             blue,
  output logic                          frame_start,
  output logic [NUM_LAYERS-2:0]         collision
);

  logic hsync_raw_s, vsync_raw_s, visible_raw_s;

  vga_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clock       (clock),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .frame_start (frame_start),
    .hsync_raw   (hsync_raw_s),
    .vsync_raw   (vsync_raw_s),
    .visible_raw (visible_raw_s)
  );

  logic             hsync_s1_q, hsync_s1_d, hsync_q, hsync_d;
  logic             vsync_s1_q, vsync_s1_d, vsync_q, vsync_d;
  logic             vis_s1_q, vis_s1_d;
  logic [RGB_W-1:0] rgb_q, rgb_d, pix_s;

  // Stage 1 lines up with the sprite register; stage 2 with the merge register.
  always_comb begin
    hsync_s1_d = hsync_raw_s;
    vsync_s1_d = vsync_raw_s;
    vis_s1_d   = visible_raw_s;
    hsync_d    = hsync_s1_q;
    vsync_d    = vsync_s1_q;
    pix_s      = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      pix_s = layer_data[i] ? layer_rgb[LAYER_W*i +: LAYER_W] : pix_s;
    end
    rgb_d = vis_s1_q ? pix_s : {RGB_W{1'b0}};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hsync_s1_q <= 1'b1;
      vsync_s1_q <= 1'b1;
      vis_s1_q   <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      rgb_q      <= {RGB_W{1'b0}};
    end else begin
      hsync_s1_q <= hsync_s1_d;
      vsync_s1_q <= vsync_s1_d;
      vis_s1_q   <= vis_s1_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      rgb_q      <= rgb_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign red   = rgb_q[RGB_W-1 -: RED_W];
  assign green = rgb_q[BLUE_W +: GREEN_W];
  assign blue  = rgb_q[BLUE_W-1:0];

`ifdef VGA_COMPOSITOR_COLLISION_EN
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [NUM_LAYERS-2:0] hit_s, acc_q, acc_d, coll_q, coll_d;
  logic                  wrap_s;

  // The wrap cycle's own hit is folded into the published value, never lost.
  always_comb begin
    wrap_s = (hcount == H_LAST) && (vcount == V_LAST);
    for (int i = 1; i < NUM_LAYERS; i++) begin
      hit_s[i-1] = layer_data[0] & layer_data[i] & vis_s1_q;
    end
    if (wrap_s) begin
      coll_d = acc_q | hit_s;
      acc_d  = {(NUM_LAYERS-1){1'b0}};
    end else begin
      coll_d = coll_q;
      acc_d  = acc_q | hit_s;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= {(NUM_LAYERS-1){1'b0}};
      coll_q <= {(NUM_LAYERS-1){1'b0}};
    end else begin
      acc_q  <= acc_d;
      coll_q <= coll_d;
    end
  end

  assign collision = coll_q;
`else
  assign collision = {(NUM_LAYERS-1){1'b0}};
`endif

endmodule

// File: tb/tb_vga_compositor.sv
// Directed bench: full 640x480 instance for reset/line/pixel checks, a shrunken
// timing instance (16x8 raster) for whole-frame sync and collision checks.
module tb_vga_compositor;

  logic clock = 1'b0;
  always #20 clock = ~clock;

  logic reset;

  logic [7:0]  f_data, s_data;
  logic [63:0] f_rgb, s_rgb;
  logic [9:0]  f_hcount, f_vcount, s_hcount, s_vcount;
  logic        f_hsync, f_vsync, s_hsync, s_vsync;
  logic [2:0]  f_red, f_green, s_red, s_green;
  logic [1:0]  f_blue, s_blue;
  logic        f_frame_start, s_frame_start;
  logic [6:0]  f_collision, s_collision;

  vga_compositor u_full (
    .clock(clock), .reset(reset), .layer_data(f_data), .layer_rgb(f_rgb),
    .hcount(f_hcount), .vcount(f_vcount), .hsync(f_hsync), .vsync(f_vsync),
    .red(f_red), .green(f_green), .blue(f_blue),
    .frame_start(f_frame_start), .collision(f_collision)
  );

  vga_compositor #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_small (
    .clock(clock), .reset(reset), .layer_data(s_data), .layer_rgb(s_rgb),
    .hcount(s_hcount), .vcount(s_vcount), .hsync(s_hsync), .vsync(s_vsync),
    .red(s_red), .green(s_green), .blue(s_blue),
    .frame_start(s_frame_start), .collision(s_collision)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] f_pix;
  assign f_pix = {f_red, f_green, f_blue};

`ifdef VGA_COMPOSITOR_COLLISION_EN
  localparam logic [6:0] COLL_EXP = 7'b0000010;
`else
  localparam logic [6:0] COLL_EXP = 7'b0000000;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_f(input int idx, input logic d, input logic [7:0] c);
    f_data[idx]       = d;
    f_rgb[8*idx +: 8] = c;
  endtask

  task automatic set_s(input int idx, input logic d, input logic [7:0] c);
    s_data[idx]       = d;
    s_rgb[8*idx +: 8] = c;
  endtask

  task automatic wait_f(input int h, input int v);
    int n;
    n = 0;
    while (!(f_hcount == 10'(h) && f_vcount == 10'(v)) && n < 2000) begin
      step();
      n++;
    end
    check("wait_f", {31'd0, (f_hcount == 10'(h) && f_vcount == 10'(v))}, 32'd1);
  endtask

  task automatic wait_s(input int h, input int v);
    int n;
    n = 0;
    while (!(s_hcount == 10'(h) && s_vcount == 10'(v)) && n < 300) begin
      step();
      n++;
    end
    check("wait_s", {31'd0, (s_hcount == 10'(h) && s_vcount == 10'(v))}, 32'd1);
  endtask

  initial begin
    int k, cnt, vlow, hlow, fs;
    reset  = 1'b1;
    f_data = 8'd0;
    f_rgb  = 64'd0;
    s_data = 8'd0;
    s_rgb  = 64'd0;
    repeat (3) step();

    check("rst_hcount", f_hcount, 32'd0);
    check("rst_vcount", f_vcount, 32'd0);
    check("rst_hsync", f_hsync, 32'd1);
    check("rst_vsync", f_vsync, 32'd1);
    check("rst_rgb", f_pix, 32'd0);
    check("rst_frame_start", f_frame_start, 32'd0);
    check("rst_collision", f_collision, 32'd0);
    check("rst_s_hcount", s_hcount, 32'd0);

    reset = 1'b0;
    step();
    check("post_rst_h1", f_hcount, 32'd1);
    step();
    check("post_rst_h2", f_hcount, 32'd2);
    step();
    check("post_rst_h3", f_hcount, 32'd3);
    check("post_rst_fs", f_frame_start, 32'd0);

    // hsync: first low two cycles after hcount=656, low for 96 cycles
    wait_f(656, 0);
    k = 0;
    while (f_hsync === 1'b1 && k < 10) begin
      step();
      k++;
    end
    check("hsync_lag", k, 32'd2);
    cnt = 0;
    while (f_hsync === 1'b0 && cnt < 200) begin
      step();
      cnt++;
    end
    check("hsync_low_len", cnt, 32'd96);

    wait_f(799, 0);
    step();
    check("wrap_hcount", f_hcount, 32'd0);
    check("wrap_vcount", f_vcount, 32'd1);

    // Priority merge with static layers on line 1
    set_f(0, 1'b1, 8'hE0);
    set_f(3, 1'b1, 8'h1F);
    wait_f(50, 1);
    check("prio_l0_over_l3", f_pix, 32'hE0);
    set_f(0, 1'b0, 8'hE0);
    wait_f(60, 1);
    check("l3_alone", f_pix, 32'h1F);
    set_f(3, 1'b0, 8'h1F);
    wait_f(70, 1);
    check("background", f_pix, 32'h01);
    set_f(3, 1'b1, 8'h1F);
    wait_f(641, 1);
    check("last_visible_px639", f_pix, 32'h1F);
    step();
    check("blank_px640", f_pix, 32'h00);
    set_f(0, 1'b1, 8'hFF);
    wait_f(702, 1);
    check("blank_h700", f_pix, 32'h00);
    wait_f(1, 2);
    check("blank_h799", f_pix, 32'h00);
    step();
    check("first_px_line2", f_pix, 32'hFF);

    // One-cycle layer pulse: sampled for counter 100, visible when hcount=102
    set_f(0, 1'b0, 8'h00);
    set_f(3, 1'b0, 8'h00);
    wait_f(100, 2);
    step();
    set_f(0, 1'b1, 8'hE0);
    check("pulse_before", f_pix, 32'h01);
    step();
    set_f(0, 1'b0, 8'h00);
    check("pulse_latency", f_pix, 32'hE0);
    step();
    check("pulse_after", f_pix, 32'h01);

    // Whole-frame checks on the 16x8 raster (128-cycle frame)
    k = 0;
    while (s_frame_start !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    check("s_fs_found", {31'd0, s_frame_start}, 32'd1);
    check("s_fs_origin", {s_hcount, s_vcount}, 32'd0);
    vlow = 0;
    hlow = 0;
    fs   = 0;
    for (int i = 0; i < 128; i++) begin
      step();
      if (s_vsync === 1'b0) vlow++;
      if (s_hsync === 1'b0) hlow++;
      if (s_frame_start === 1'b1) fs++;
    end
    check("s_vsync_low", vlow, 32'd32);
    check("s_hsync_low", hlow, 32'd24);
    check("s_fs_count", fs, 32'd1);
    check("s_fs_period", {31'd0, s_frame_start}, 32'd1);
    check("coll_frame_n_start", s_collision, 32'd0);

    // Frame N: visible overlap of layers 0,2 at (2,1); blanked overlap 0,5 at (10,1)
    wait_s(2, 1);
    step();
    set_s(0, 1'b1, 8'hE0);
    set_s(2, 1'b1, 8'h1C);
    step();
    set_s(0, 1'b0, 8'h00);
    set_s(2, 1'b0, 8'h00);
    wait_s(10, 1);
    step();
    set_s(0, 1'b1, 8'hE0);
    set_s(5, 1'b1, 8'h03);
    step();
    set_s(0, 1'b0, 8'h00);
    set_s(5, 1'b0, 8'h00);
    check("coll_frame_n_hold", s_collision, 32'd0);

    wait_s(0, 0);
    check("coll_frame_n1_start", s_collision, {25'd0, COLL_EXP});
    repeat (100) step();
    check("coll_frame_n1_late", s_collision, {25'd0, COLL_EXP});
    wait_s(0, 0);
    check("coll_frame_n2_clear", s_collision, 32'd0);
    check("full_coll_zero", f_collision, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
